// File: rtl/spart_pkg.sv
// Shared types and constants for the mini SPART.
// Used by the receiver, transmitter and baud generator.
package spart_pkg;

  localparam int SPART_OVERSAMPLE = 16;
  localparam int SPART_MID_TICK   = 7;
  localparam int SPART_BAUD_W     = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/spart_rx_sync2.sv
// Two-flop synchronizer for asynchronous inputs.
// The reset value is a parameter so an idle-high line resets to 1.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/spart_rx.sv
// mini SPART receiver: 8N1 frames from rxd,
// timed by the oversample tick en.
module spart_rx
  import spart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = SPART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 rxd,
  input  logic                 rd_clr,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW =
    (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] MID_T =
    TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TMAX =
    TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BMAX =
    BW'(DATA_BITS - 1);

  logic rxd_s;

  rx_state_t state_q, state_d;

  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 rda_q, rda_d;
  logic                 fe_q, fe_d;
  logic                 ovr_q, ovr_d;

  logic at_mid;
  logic at_wrap;
  logic last_bit;
  logic sample;
  logic done;

  sync2 #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rxd),
    .q  (rxd_s)
  );

  assign at_mid   = (tick_q == MID_T);
  assign at_wrap  = (tick_q == TMAX);
  assign last_bit = (bit_q == BMAX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      rda_q   <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rda_q   <= rda_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (en) begin
      unique case (state_q)
        IDLE:
          if (!rxd_s) state_d = START;
        START:
          if (at_mid)
            state_d = rxd_s ? IDLE : DATA;
        DATA:
          if (at_wrap && last_bit)
            state_d = STOP;
        STOP:
          if (at_wrap) state_d = IDLE;
        default:
          state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    sample  = en && (state_q == DATA) && at_wrap;
    done    = en && (state_q == STOP) && at_wrap;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          tick_d = '0;
          bit_d  = '0;
        end
        START: begin
          tick_d = at_mid ? '0 : tick_q + 1'b1;
          bit_d  = '0;
        end
        // tick_cnt wraps naturally: OVERSAMPLE is 2^TW
        DATA:    tick_d = tick_q + 1'b1;
        STOP:    tick_d = tick_q + 1'b1;
        default: tick_d = '0;
      endcase
    end
    if (sample) begin
      bit_d   = bit_q + 1'b1;
      shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
    end
  end

  always_comb begin
    data_d = data_q;
    rda_d  = rda_q;
    fe_d   = fe_q;
    ovr_d  = ovr_q;
    // completion takes priority over a same-cycle rd_clr
    if (done) begin
      data_d = shift_q;
      rda_d  = 1'b1;
      fe_d   = ~rxd_s;
      ovr_d  = rda_q & ~rd_clr;
    end else if (rd_clr) begin
      rda_d  = 1'b0;
      ovr_d  = 1'b0;
    end
  end

  assign rx_data   = data_q;
  assign rda       = rda_q;
  assign frame_err = fe_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_spart_rx.sv
// Randomized bench for spart_rx against a
// frame-level model of the receiver status.
module tb_spart_rx;
  import spart_pkg::*;

  logic       clk;
  logic       rst;
  logic       en;
  logic       rxd;
  logic       rd_clr;
  logic [7:0] rx_data;
  logic       rda;
  logic       frame_err;
  logic       overrun;

  int checks;
  int errors;

  logic [7:0] m_data;
  logic       m_rda;
  logic       m_fe;
  logic       m_ovr;

  spart_rx dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .rxd      (rxd),
    .rd_clr   (rd_clr),
    .rx_data  (rx_data),
    .rda      (rda),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    en = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic chk(string tag,
                     logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h",
               tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, "_data"}, 32'(rx_data), 32'(m_data));
    chk({tag, "_rda"}, 32'(rda), 32'(m_rda));
    chk({tag, "_fe"}, 32'(frame_err), 32'(m_fe));
    chk({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
  endtask

  task automatic model_reset();
    m_data = '0;
    m_rda  = 1'b0;
    m_fe   = 1'b0;
    m_ovr  = 1'b0;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!en) @(posedge clk);
    end
    #1;
  endtask

  // Returns just after the en edge that sees
  // the synchronized start edge.
  task automatic start_edge();
    rxd = 1'b0;
    repeat (2) @(posedge clk);
    @(posedge clk);
    while (!en) @(posedge clk);
  endtask

  task automatic send(logic [7:0] b,
                      logic stop,
                      bit coinc,
                      string tag);
    start_edge();
    ticks(16);
    for (int k = 0; k < 8; k++) begin
      rxd = b[k];
      ticks(16);
    end
    rxd = stop;
    if (coinc) begin
      ticks(7);
      @(negedge clk);
      #1;
      while (!en) begin
        @(negedge clk);
        #1;
      end
      rd_clr = 1'b1;
      @(posedge clk);
      #1;
      rd_clr = 1'b0;
    end else begin
      ticks(8);
    end
    rxd    = 1'b1;
    m_ovr  = coinc ? 1'b0 : m_rda;
    m_rda  = 1'b1;
    m_data = b;
    m_fe   = ~stop;
    check_all(tag);
  endtask

  task automatic rd_pulse(string tag);
    @(negedge clk);
    rd_clr = 1'b1;
    @(posedge clk);
    #1;
    rd_clr = 1'b0;
    m_rda  = 1'b0;
    m_ovr  = 1'b0;
    chk({tag, "_rda"}, 32'(rda), 32'(m_rda));
    chk({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs;
    bit         rc;
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    rxd    = 1'b0;
    rd_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset_state", 32'(dut.state_q), 32'(IDLE));
    rxd = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    ticks(20);
    check_all("idle");

    send(8'hA5, 1'b1, 1'b0, "a5");
    rd_pulse("a5_clr");

    rxd = 1'b0;
    ticks(4);
    rxd = 1'b1;
    ticks(20);
    check_all("glitch");
    chk("glitch_state", 32'(dut.state_q), 32'(IDLE));
    send(8'h3C, 1'b1, 1'b0, "3c");
    rd_pulse("3c_clr");

    send(8'h55, 1'b0, 1'b0, "55fe");
    rd_pulse("55_clr");
    send(8'h0F, 1'b1, 1'b0, "0f");
    rd_pulse("0f_clr");

    send(8'h12, 1'b1, 1'b0, "12");
    send(8'h34, 1'b1, 1'b0, "34ovr");
    rd_pulse("34_clr");

    send(8'h66, 1'b1, 1'b0, "66");
    send(8'h77, 1'b1, 1'b1, "77coinc");
    rd_pulse("77_clr");

    send(8'h99, 1'b1, 1'b0, "99");
    start_edge();
    ticks(16);
    rb = 8'hE6;
    for (int k = 0; k < 3; k++) begin
      rxd = rb[k];
      ticks(16);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    check_all("rst_mid");
    rxd = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    ticks(4);
    send(8'hC0, 1'b1, 1'b0, "c0");

    for (int i = 0; i < 20; i++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(3) != 0);
      rc = 1'($urandom_range(1));
      send(rb, rs, rc, "rnd");
      if ($urandom_range(2) == 0)
        rd_pulse("rnd_clr");
      ticks(1 + $urandom_range(5));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
